timer_bank: RTL and testbench

- N-channel programmable timer bank: the next generation of the single-channel baud/alarm timer.
- Adds a shared prescaler, a periodic or one-shot mode per channel, done status, and a magnitude-safe terminal compare.
- Used for UART baud and oversample ticks, RX timeouts and general protocol delays from one block.
- One prescaler tick feeds all channels; each channel raises a one-cycle registered alarm at its terminal count.

---
 rtl/timer_bank.sv | 120 ++++++++++++
 tb/tb_timer_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// N-channel timer bank: one shared prescaler, per-channel periodic/one-shot counters with one-cycle alarms.
// Optional interrupt status/clear logic is built when TIMER_BANK_IRQ_EN is defined.
module timer_bank #(
    parameter int CH    = 2,
    parameter int W     = 16,
    parameter int PRE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [CH-1:0]     en,
    input  logic [CH-1:0]     oneshot,
    input  logic [CH*W-1:0]   cnt_val,
    output logic [CH-1:0]     alarm,
    output logic [CH-1:0]     done
`ifdef TIMER_BANK_IRQ_EN
    ,
    input  logic [CH-1:0]     irq_clr,
    output logic [CH-1:0]     irq_stat,
    output logic              irq
`endif
);

    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;
    logic [W-1:0]     count_r   [CH];
    logic [W-1:0]     count_nxt_s [CH];
    logic [CH-1:0]    alarm_r;
    logic [CH-1:0]    alarm_nxt_s;
    logic [CH-1:0]    done_r;
    logic [CH-1:0]    done_nxt_s;

    // >= rather than == so a lowered prescale takes effect without a wrap
    assign tick_s = run && (pre_cnt_r >= prescale);

    // Shared prescaler counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else if (!run || tick_s) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + 1'b1;
        end
    end

    // Per-channel next-state: disable clears, terminal wraps to 0 and raises alarm
    always_comb begin
        count_nxt_s = count_r;
        alarm_nxt_s = {CH{1'b0}};
        done_nxt_s  = done_r;
        for (int i = 0; i < CH; i++) begin
            if (!en[i]) begin
                count_nxt_s[i] = {W{1'b0}};
                done_nxt_s[i]  = 1'b0;
            end else if (tick_s && !done_r[i]) begin
                if (count_r[i] >= cnt_val[i*W +: W]) begin
                    count_nxt_s[i] = {W{1'b0}};
                    alarm_nxt_s[i] = 1'b1;
                    done_nxt_s[i]  = oneshot[i];
                end else begin
                    count_nxt_s[i] = count_r[i] + 1'b1;
                end
            end else begin
                count_nxt_s[i] = count_r[i];
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                count_r[i] <= {W{1'b0}};
            end
            alarm_r <= {CH{1'b0}};
            done_r  <= {CH{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            alarm_r <= alarm_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign alarm = alarm_r;
    assign done  = done_r;

`ifdef TIMER_BANK_IRQ_EN
    logic [CH-1:0] irq_stat_r;
    logic [CH-1:0] irq_nxt_s;

    // Sticky status: a new alarm beats a simultaneous clear; channel disable leaves it alone
    always_comb begin
        irq_nxt_s = irq_stat_r;
        for (int i = 0; i < CH; i++) begin
            if (alarm_nxt_s[i]) begin
                irq_nxt_s[i] = 1'b1;
            end else if (irq_clr[i]) begin
                irq_nxt_s[i] = 1'b0;
            end else begin
                irq_nxt_s[i] = irq_stat_r[i];
            end
        end
    end

    // Interrupt status register
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_stat_r <= {CH{1'b0}};
        end else begin
            irq_stat_r <= irq_nxt_s;
        end
    end

    assign irq_stat = irq_stat_r;
    assign irq      = |irq_stat_r;
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: stimulus queues expected alarm cycles, a negedge monitor matches them.
// Interrupt checks are included when TIMER_BANK_IRQ_EN is defined.
module tb_timer_bank;

    localparam int CH    = 2;
    localparam int W     = 8;
    localparam int PRE_W = 8;

    logic              clk;
    logic              rst;
    logic              run;
    logic [PRE_W-1:0]  prescale;
    logic [CH-1:0]     en;
    logic [CH-1:0]     oneshot;
    logic [W-1:0]      cv0;
    logic [W-1:0]      cv1;
    logic [CH*W-1:0]   cnt_val;
    logic [CH-1:0]     alarm;
    logic [CH-1:0]     done;
`ifdef TIMER_BANK_IRQ_EN
    logic [CH-1:0]     irq_clr;
    logic [CH-1:0]     irq_stat;
    logic              irq;
`endif

    assign cnt_val = {cv1, cv0};

    timer_bank #(.CH(CH), .W(W), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .prescale (prescale),
        .en       (en),
        .oneshot  (oneshot),
        .cnt_val  (cnt_val),
        .alarm    (alarm),
        .done     (done)
`ifdef TIMER_BANK_IRQ_EN
        ,
        .irq_clr  (irq_clr),
        .irq_stat (irq_stat),
        .irq      (irq)
`endif
    );

    typedef struct {
        int cyc;
        int ch;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges; at a negedge, cyc equals the number of edges so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_alarm(input int at_cyc, input int ch);
        exp_t e;
        e.cyc = at_cyc;
        e.ch  = ch;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: every observed alarm pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_alarm: ch %0d expected at cycle %0d, no pulse by cycle %0d",
                         exp_q[0].ch, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            for (int c = 0; c < CH; c++) begin
                if (alarm[c]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_alarm: ch %0d at cycle %0d, expected none", c, cyc);
                    end else if (exp_q[0].cyc != cyc || exp_q[0].ch != c) begin
                        n_fail++;
                        $display("FAIL alarm_match: got ch %0d at cycle %0d, expected ch %0d at cycle %0d",
                                 c, cyc, exp_q[0].ch, exp_q[0].cyc);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int d;
        rst      = 1'b1;
        run      = 1'b1;
        prescale = 8'd0;
        en       = 2'b11;
        oneshot  = 2'b00;
        cv0      = 8'd3;
        cv1      = 8'd3;
`ifdef TIMER_BANK_IRQ_EN
        irq_clr  = 2'b00;
`endif

        // Reset held two cycles, then first cycle after release
        @(negedge clk);
        check("rst_alarm_1", {30'd0, alarm}, 32'd0);
        check("rst_done_1", {30'd0, done}, 32'd0);
        @(negedge clk);
        check("rst_alarm_2", {30'd0, alarm}, 32'd0);
        check("rst_done_2", {30'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_alarm", {30'd0, alarm}, 32'd0);
        check("post_rst_done", {30'd0, done}, 32'd0);
`ifdef TIMER_BANK_IRQ_EN
        check("post_rst_irq", {31'd0, irq}, 32'd0);
`endif
        en = 2'b00;
        @(negedge clk);

        // Periodic, no prescale: cnt_val0=3 -> period 4
        c = cyc;
        en = 2'b01;
        expect_alarm(c + 4, 0);
        expect_alarm(c + 8, 0);
        expect_alarm(c + 12, 0);
        expect_alarm(c + 16, 0);
        wait_to(c + 17);
        en = 2'b00;
        @(negedge clk);

        // Prescaled: prescale=2, cnt_val0=1 -> period 6
        c = cyc;
        prescale = 8'd2;
        cv0 = 8'd1;
        en = 2'b01;
        expect_alarm(c + 6, 0);
        expect_alarm(c + 12, 0);
        expect_alarm(c + 18, 0);
        wait_to(c + 19);
        en = 2'b00;
        prescale = 8'd0;
        @(negedge clk);
        @(negedge clk);

        // Enable dropping on the terminal tick suppresses the alarm
        c = cyc;
        cv0 = 8'd2;
        en = 2'b01;
        wait_to(c + 2);
        en = 2'b00;
        @(negedge clk);
        check("clear_wins_alarm", {30'd0, alarm}, 32'd0);
        @(negedge clk);

        // Both zero: alarm every cycle
        c = cyc;
        cv0 = 8'd0;
        en = 2'b01;
        for (int k = 1; k <= 5; k++) expect_alarm(c + k, 0);
        wait_to(c + 5);
        en = 2'b00;
        @(negedge clk);

        // One-shot on channel 1
        c = cyc;
        cv1 = 8'd5;
        oneshot = 2'b10;
        en = 2'b10;
        expect_alarm(c + 6, 1);
        wait_to(c + 5);
        check("oneshot_done_before", {31'd0, done[1]}, 32'd0);
        wait_to(c + 6);
        check("oneshot_done_set", {31'd0, done[1]}, 32'd1);
        wait_to(c + 56);
        check("oneshot_done_held", {31'd0, done[1]}, 32'd1);
        en = 2'b00;
        @(negedge clk);
        check("oneshot_done_cleared", {31'd0, done[1]}, 32'd0);
        d = cyc;
        en = 2'b10;
        expect_alarm(d + 6, 1);
        wait_to(d + 6);
        check("oneshot_rearm_done", {31'd0, done[1]}, 32'd1);
        en = 2'b00;
        oneshot = 2'b00;
        @(negedge clk);

        // Compare lowered below the running count: fires on next tick, no wrap
        c = cyc;
        cv0 = 8'd200;
        en = 2'b01;
        wait_to(c + 100);
        cv0 = 8'd50;
        expect_alarm(c + 101, 0);
        expect_alarm(c + 152, 0);
        expect_alarm(c + 203, 0);
        wait_to(c + 204);
        en = 2'b00;
        @(negedge clk);

`ifdef TIMER_BANK_IRQ_EN
        // Interrupt status: set by alarm, W1C, set beats clear, survives disable
        c = cyc;
        cv0 = 8'd3;
        en = 2'b01;
        expect_alarm(c + 4, 0);
        expect_alarm(c + 8, 0);
        wait_to(c + 4);
        check("irq_stat_set", {31'd0, irq_stat[0]}, 32'd1);
        check("irq_set", {31'd0, irq}, 32'd1);
        wait_to(c + 5);
        irq_clr = 2'b01;
        wait_to(c + 6);
        irq_clr = 2'b00;
        check("irq_stat_cleared", {31'd0, irq_stat[0]}, 32'd0);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wait_to(c + 7);
        irq_clr = 2'b01;
        wait_to(c + 8);
        check("irq_set_beats_clr", {31'd0, irq_stat[0]}, 32'd1);
        irq_clr = 2'b00;
        en = 2'b00;
        wait_to(c + 10);
        check("irq_survives_disable", {31'd0, irq_stat[0]}, 32'd1);
        irq_clr = 2'b01;
        @(negedge clk);
        check("irq_final_clear", {31'd0, irq}, 32'd0);
        irq_clr = 2'b00;
`endif

        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_alarm: ch %0d expected at cycle %0d, never seen",
                     exp_q[0].ch, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
